// File: rtl/framebuffer_writer_pkg.sv
// Shared types and default geometry for the framebuffer write path.
// The writer takes its sizes as parameters. The constants here give the
// default 512x384 frame, 16-bit colour and 18-bit pixel BRAM address.
package framebuffer_writer_pkg;

   localparam int FRAME_WIDTH     = 512;
   localparam int FRAME_HEIGHT    = 384;
   localparam int PBRAM_ADDR_BITS = 18;
   localparam int COLOR_WIDTH     = 16;
   localparam int COORD_BITS      = 16;
   localparam int FIFO_DEPTH      = 8;

   typedef logic [COORD_BITS-1:0]      ScreenX;
   typedef logic [COORD_BITS-1:0]      ScreenY;
   typedef logic [PBRAM_ADDR_BITS-1:0] FramebufferAddr;

   // One queued pixel, packed in the same order the FIFO stores it.
   typedef struct packed {
      ScreenX      x;
      ScreenY      y;
      logic [15:0] color;
   } PixelWrite;

   // FINISH is the single cycle after the last clear write. In that cycle
   // the write enable drops and clear_done pulses.
   typedef enum logic [1:0] {
      ST_DRAIN  = 2'd0,
      ST_CLEAR  = 2'd1,
      ST_FINISH = 2'd2
   } fbw_state_e;

endpackage

// File: rtl/framebuffer_writer_if.sv
// Pixel stream handshake from the raytracing controller into the writer.
// master = pixel producer, slave = framebuffer_writer.
interface framebuffer_writer_if #(
   parameter int COORD_BITS  = framebuffer_writer_pkg::COORD_BITS,
   parameter int COLOR_WIDTH = framebuffer_writer_pkg::COLOR_WIDTH
);
   import framebuffer_writer_pkg::*;

   logic                   pix_valid_in;
   logic [COORD_BITS-1:0]  pix_x_in;
   logic [COORD_BITS-1:0]  pix_y_in;
   logic [COLOR_WIDTH-1:0] pix_color_in;
   logic                   pix_ready_out;

   modport master (
      output pix_valid_in,
      output pix_x_in,
      output pix_y_in,
      output pix_color_in,
      input  pix_ready_out
   );

   modport slave (
      input  pix_valid_in,
      input  pix_x_in,
      input  pix_y_in,
      input  pix_color_in,
      output pix_ready_out
   );

endinterface

// File: rtl/framebuffer_writer_fifo.sv
// Small synchronous FIFO for queued pixels.
// The head entry is presented combinationally whenever empty_o is low, so a
// pop and its data are used in the same cycle. Pushing while full and
// popping while empty are both ignored.
module pixel_fifo #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   // The extra MSB on each pointer tells a full FIFO apart from an empty one.
   logic [PW:0]      wr_ptr_q;
   logic [PW:0]      rd_ptr_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                    (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q[PW-1:0]];

   // Storage write; the contents need no reset because the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[PW-1:0]] <= wdata_i;
      end
   end

   // Pointer update; reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

endmodule

// File: rtl/framebuffer_writer.sv
// Framebuffer writer: queues shaded pixels, drops off-screen ones, turns
// (x, y) into a linear BRAM address and drives pixel_bram port A. On
// request it sweeps the whole frame with a clear colour. The controller
// therefore never has to drive the BRAM itself.
module framebuffer_writer #(
   parameter int FRAME_WIDTH  = framebuffer_writer_pkg::FRAME_WIDTH,
   parameter int FRAME_HEIGHT = framebuffer_writer_pkg::FRAME_HEIGHT,
   parameter int COLOR_WIDTH  = framebuffer_writer_pkg::COLOR_WIDTH,
   parameter int COORD_BITS   = framebuffer_writer_pkg::COORD_BITS,
   parameter int ADDR_BITS    = framebuffer_writer_pkg::PBRAM_ADDR_BITS,
   parameter int FIFO_DEPTH   = framebuffer_writer_pkg::FIFO_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   framebuffer_writer_if.slave    pix_if,
   input  logic                   clear_req,
   input  logic [COLOR_WIDTH-1:0] clear_color,
   output logic                   clearing_out,
   output logic                   clear_done,
   output logic                   bram_we,
   output logic [ADDR_BITS-1:0]   bram_addr,
   output logic [COLOR_WIDTH-1:0] bram_din,
   output logic [31:0]            pixel_count,
   output logic [15:0]            dropped_count
);
   import framebuffer_writer_pkg::*;

   // FRAME_WIDTH is a power of two, so the row offset is a plain shift.
   localparam int                    XSHIFT    = $clog2(FRAME_WIDTH);
   localparam int                    ENTRY_W   = 2 * COORD_BITS + COLOR_WIDTH;
   localparam logic [COORD_BITS:0]   X_LIMIT   = (COORD_BITS + 1)'(FRAME_WIDTH);
   localparam logic [COORD_BITS:0]   Y_LIMIT   = (COORD_BITS + 1)'(FRAME_HEIGHT);
   localparam logic [ADDR_BITS-1:0]  LAST_ADDR = ADDR_BITS'(FRAME_WIDTH * FRAME_HEIGHT - 1);

   fbw_state_e             state_q;
   logic                   clearing_q;
   logic                   clear_done_q;
   logic                   bram_we_q;
   logic [ADDR_BITS-1:0]   bram_addr_q;
   logic [COLOR_WIDTH-1:0] bram_din_q;
   logic [ADDR_BITS-1:0]   clear_cnt_q;
   logic [COLOR_WIDTH-1:0] clear_color_q;
   logic [31:0]            pixel_count_q;
   logic [15:0]            dropped_q;

   logic                   ready;
   logic                   accept;
   logic                   in_range;
   logic                   push;
   logic                   pop;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [ENTRY_W-1:0]     wr_entry;
   logic [ENTRY_W-1:0]     rd_entry;
   logic [COORD_BITS-1:0]  rd_x;
   logic [COORD_BITS-1:0]  rd_y;
   logic [COLOR_WIDTH-1:0] rd_color;
   logic [ADDR_BITS-1:0]   pix_addr_d;

   // Ready is the only unregistered output. It must fall in the same cycle the FIFO fills.
   assign ready                = !fifo_full && !clearing_q;
   assign pix_if.pix_ready_out = ready;
   assign accept               = pix_if.pix_valid_in && ready;
   assign in_range             = ({1'b0, pix_if.pix_x_in} < X_LIMIT) &&
                                 ({1'b0, pix_if.pix_y_in} < Y_LIMIT);
   assign push                 = accept && in_range;
   assign pop                  = (state_q == ST_DRAIN) && !fifo_empty;
   assign wr_entry             = {pix_if.pix_x_in, pix_if.pix_y_in, pix_if.pix_color_in};
   assign {rd_x, rd_y, rd_color} = rd_entry;

   // Linear address of the head pixel: row shifted up past the column bits, plus column.
   always_comb begin
      pix_addr_d = (ADDR_BITS'(rd_y) << XSHIFT) + ADDR_BITS'(rd_x);
   end

   pixel_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .wdata_i (wr_entry),
      .pop_i   (pop),
      .rdata_o (rd_entry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Control FSM plus every registered output. DRAIN empties the FIFO before
   // a pending clear may start, so pixels already accepted always land first.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_DRAIN;
         clearing_q    <= 1'b0;
         clear_done_q  <= 1'b0;
         bram_we_q     <= 1'b0;
         bram_addr_q   <= '0;
         bram_din_q    <= '0;
         clear_cnt_q   <= '0;
         clear_color_q <= '0;
         pixel_count_q <= '0;
         dropped_q     <= '0;
      end else begin
         clear_done_q <= 1'b0;

         // A request that arrives while a clear is pending or running is dropped, not queued.
         if (clear_req && !clearing_q) begin
            clearing_q    <= 1'b1;
            clear_color_q <= clear_color;
         end

         if (accept && !in_range && (dropped_q != 16'hFFFF)) begin
            dropped_q <= dropped_q + 16'd1;
         end

         case (state_q)
            ST_DRAIN: begin
               if (pop) begin
                  bram_we_q     <= 1'b1;
                  bram_addr_q   <= pix_addr_d;
                  bram_din_q    <= rd_color;
                  pixel_count_q <= pixel_count_q + 32'd1;
               end else begin
                  bram_we_q <= 1'b0;
                  if (clearing_q) begin
                     state_q     <= ST_CLEAR;
                     clear_cnt_q <= '0;
                  end
               end
            end
            ST_CLEAR: begin
               bram_we_q   <= 1'b1;
               bram_addr_q <= clear_cnt_q;
               bram_din_q  <= clear_color_q;
               clear_cnt_q <= clear_cnt_q + 1'b1;
               if (clear_cnt_q == LAST_ADDR) begin
                  state_q <= ST_FINISH;
               end
            end
            ST_FINISH: begin
               bram_we_q    <= 1'b0;
               clear_done_q <= 1'b1;
               clearing_q   <= 1'b0;
               state_q      <= ST_DRAIN;
            end
            default: begin
               bram_we_q <= 1'b0;
               state_q   <= ST_DRAIN;
            end
         endcase
      end
   end

   assign clearing_out  = clearing_q;
   assign clear_done    = clear_done_q;
   assign bram_we       = bram_we_q;
   assign bram_addr     = bram_addr_q;
   assign bram_din      = bram_din_q;
   assign pixel_count   = pixel_count_q;
   assign dropped_count = dropped_q;

endmodule
